// File: rtl/sw_led_panel.sv
// Switch-to-LED front panel: per-bit synchroniser, debouncer and rise detector driving LEDs in
// direct, toggle, chase or blink mode. Define SW_LED_BLINK_EN to add the blink phase for mode 11.
module sw_led_panel #(
    parameter int WIDTH      = 16,
    parameter int DEB_CYCLES = 1000,
    parameter int TICK_DIV   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0]    sync1_r;
    logic [WIDTH-1:0]    sync2_r;
    logic [WIDTH-1:0]    stable_r;
    logic [WIDTH-1:0]    stable_d_r;
    logic [WIDTH-1:0]    rise_r;
    logic [WIDTH-1:0]    tgl_r;
    logic [WIDTH-1:0]    chase_r;
    logic [WIDTH-1:0]    led_r;
    logic [CW-1:0]       cnt_r [WIDTH];
    logic [TICK_DIV-1:0] div_r;
    logic                tick_s;

    // Index arithmetic keeps the rotations legal for WIDTH == 1.
    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[(i + WIDTH - 1) % WIDTH];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[(i + 1) % WIDTH];
        return r;
    endfunction

    assign tick_s = (div_r == {TICK_DIV{1'b1}});

    // Two-flop synchroniser for the raw switch pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= sw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a change is accepted only after DEB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DEB_LAST) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // Rise detect on the debounced state, then fold rises into the toggle latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d_r <= '0;
            rise_r     <= '0;
            tgl_r      <= '0;
        end else begin
            stable_d_r <= stable_r;
            rise_r     <= stable_r & ~stable_d_r;
            tgl_r      <= tgl_r ^ rise_r;
        end
    end

    // Free-running divider and the chase pattern it steps; direction follows sw_stable[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= '0;
            chase_r <= WIDTH'(1);
        end else begin
            div_r <= div_r + TICK_DIV'(1);
            if (tick_s) begin
                chase_r <= stable_r[0] ? rot_right(chase_r) : rot_left(chase_r);
            end else begin
                chase_r <= chase_r;
            end
        end
    end

`ifdef SW_LED_BLINK_EN
    logic phase_r;

    // Blink phase flips on every divider tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else if (tick_s) begin
            phase_r <= ~phase_r;
        end else begin
            phase_r <= phase_r;
        end
    end
`endif

    // LED source select, one cycle behind the selected source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= '0;
        end else begin
            case (mode)
                2'b00:   led_r <= stable_r;
                2'b01:   led_r <= tgl_r;
                2'b10:   led_r <= chase_r;
`ifdef SW_LED_BLINK_EN
                2'b11:   led_r <= stable_r & {WIDTH{phase_r}};
`else
                2'b11:   led_r <= stable_r;
`endif
                default: led_r <= stable_r;
            endcase
        end
    end

    assign led       = led_r;
    assign sw_stable = stable_r;
    assign sw_rise   = rise_r;

endmodule

// File: tb/tb_sw_led_panel.sv
// Randomised self-checking bench for sw_led_panel (WIDTH=4, DEB_CYCLES=4, TICK_DIV=3) against a
// cycle-level behavioural model of the panel's rules.
module tb_sw_led_panel;

    localparam int W   = 4;
    localparam int DEB = 4;
    localparam int PER = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw = '0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] led, sw_stable, sw_rise;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [W-1:0] m_p1, m_p2, m_stab, m_prev, m_rise, m_tgl, m_led;
    int           m_run [W];
    int           m_pos;
    int           m_cyc;
    bit           m_phase;

    sw_led_panel #(.WIDTH(W), .DEB_CYCLES(DEB), .TICK_DIV(3)) dut (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode),
        .led(led), .sw_stable(sw_stable), .sw_rise(sw_rise)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_stab = '0; m_prev = '0;
        m_rise = '0; m_tgl = '0; m_led = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_pos = 0; m_cyc = 0; m_phase = 1'b0;
    endtask

    task automatic model_advance();
        logic [W-1:0] n_stab;
        logic [W-1:0] n_led;
        bit           tick;
        tick = ((m_cyc % PER) == PER - 1);
        case (mode)
            2'b00:   n_led = m_stab;
            2'b01:   n_led = m_tgl;
            2'b10:   n_led = W'(1 << m_pos);
`ifdef SW_LED_BLINK_EN
            default: n_led = m_phase ? m_stab : '0;
`else
            default: n_led = m_stab;
`endif
        endcase
        n_stab = m_stab;
        for (int i = 0; i < W; i++) begin
            if (m_p2[i] != m_stab[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEB) begin
                    n_stab[i] = m_p2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (tick) m_pos = m_stab[0] ? (m_pos + W - 1) % W : (m_pos + 1) % W;
        m_tgl   = m_tgl ^ m_rise;
        m_rise  = m_stab & ~m_prev;
        m_prev  = m_stab;
        m_stab  = n_stab;
        m_led   = n_led;
        m_p2    = m_p1;
        m_p1    = sw;
        m_phase = m_phase ^ tick;
        m_cyc   = m_cyc + 1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_advance();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sw = 4'h0; mode = 2'b00; rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== 12'h000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d led=%h stable=%h rise=%h want all 0", c, led, sw_stable, sw_rise);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== 12'h000 || {m_led, m_stab, m_rise} !== 12'h000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d led=%h stable=%h rise=%h want all 0", c, led, sw_stable, sw_rise);
            end
        end
    endtask

    task automatic test_direct();
        int first;
        first = 0;
        mode = 2'b00;
        sw = 4'h5;
        for (int c = 1; c <= 20; c++) begin
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                bad++;
                $display("FAIL direct cyc=%0d led=%h/%h stable=%h/%h rise=%h/%h", c, led, m_led, sw_stable, m_stab, sw_rise, m_rise);
            end
            if (first == 0 && sw_stable === 4'h5) first = c;
            if (c == 7) begin
                total++;
                if (sw_rise !== 4'h5 || led !== 4'h5) begin
                    bad++;
                    $display("FAIL direct_rise rise=%h led=%h want 5/5", sw_rise, led);
                end
            end
            if (c == 8) begin
                total++;
                if (sw_rise !== 4'h0) begin
                    bad++;
                    $display("FAIL direct_rise_width rise=%h want 0", sw_rise);
                end
            end
        end
        total++;
        if (first != 6) begin
            bad++;
            $display("FAIL direct_latency got=%0d want=6", first);
        end
        sw = 4'h0;
        for (int c = 0; c < 10; c++) step();
    endtask

    task automatic test_glitch();
        mode = 2'b00;
        for (int c = 0; c < 16; c++) begin
            sw = (c < 3) ? 4'h1 : 4'h0;
            step();
            total++;
            if (sw_stable !== 4'h0 || sw_rise !== 4'h0 || {led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                bad++;
                $display("FAIL glitch cyc=%0d stable=%h rise=%h led=%h/%h want stable=0 rise=0", c, sw_stable, sw_rise, led, m_led);
            end
        end
    endtask

    task automatic test_toggle();
        pulse_reset();
        mode = 2'b01;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 16; c++) begin
                sw = (c < 8) ? 4'h2 : 4'h0;
                step();
                total++;
                if ({led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                    bad++;
                    $display("FAIL toggle p=%0d cyc=%0d led=%h/%h stable=%h/%h rise=%h/%h", p, c, led, m_led, sw_stable, m_stab, sw_rise, m_rise);
                end
            end
            total++;
            if (led !== ((p == 0) ? 4'h2 : 4'h0)) begin
                bad++;
                $display("FAIL toggle_latch p=%0d led=%h want=%h", p, led, (p == 0) ? 4'h2 : 4'h0);
            end
        end
    endtask

    task automatic test_chase();
        pulse_reset();
        mode = 2'b10;
        for (int c = 0; c < 90; c++) begin
            sw = (c < 45) ? 4'h0 : 4'h1;
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                bad++;
                $display("FAIL chase cyc=%0d led=%h/%h stable=%h/%h rise=%h/%h", c, led, m_led, sw_stable, m_stab, sw_rise, m_rise);
            end
        end
    endtask

    task automatic test_blink_reset();
        mode = 2'b11;
        sw = 4'hF;
        for (int c = 0; c < 37; c++) begin
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                bad++;
                $display("FAIL blink cyc=%0d led=%h/%h stable=%h/%h", c, led, m_led, sw_stable, m_stab);
            end
        end
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({led, sw_stable, sw_rise} !== 12'h000) begin
            bad++;
            $display("FAIL async_reset led=%h stable=%h rise=%h want all 0", led, sw_stable, sw_rise);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                bad++;
                $display("FAIL rerise cyc=%0d led=%h/%h stable=%h/%h rise=%h/%h", c, led, m_led, sw_stable, m_stab, sw_rise, m_rise);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) sw = W'($urandom);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            step();
            total++;
            if ({led, sw_stable, sw_rise} !== {m_led, m_stab, m_rise}) begin
                bad++;
                $display("FAIL random cyc=%0d mode=%0d led=%h/%h stable=%h/%h rise=%h/%h", c, mode, led, m_led, sw_stable, m_stab, sw_rise, m_rise);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_glitch();
        test_toggle();
        test_chase();
        test_blink_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
